// File: rtl/ic_refill_ctrl_pkg.sv
// Shared refill-engine definitions: state encodings, line geometry, word offsets.
package ic_refill_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int RF_LINE_WORDS = 4;

  localparam logic [1:0] WORD0 = 2'd0;
  localparam logic [1:0] WORD1 = 2'd1;
  localparam logic [1:0] WORD2 = 2'd2;
  localparam logic [1:0] WORD3 = 2'd3;

  typedef enum logic [2:0] {
    RF_IDLE = 3'd0,
    RF_REQ  = 3'd1,
    RF_WAIT = 3'd2,
    RF_FILL = 3'd3,
    RF_DONE = 3'd4
  } rf_state_t;

  function automatic logic [1:0] next_word(input logic [1:0] k);
    return k + 2'd1;
  endfunction

endpackage

// File: rtl/ic_refill_ctrl_line_buf.sv
// Line buffer: RF_LINE_WORDS x WORD_W registers written by word index, clearable,
// presented as one concatenated line with word k at bits [WORD_W*k +: WORD_W].
module ic_refill_ctrl_line_buf
  import ic_refill_ctrl_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_clr,
  input  logic                            i_we,
  input  logic [1:0]                      i_idx,
  input  logic [WORD_W-1:0]               i_wdata,
  output logic [RF_LINE_WORDS*WORD_W-1:0] o_line
);

  logic [WORD_W-1:0] r_word [RF_LINE_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      for (int i = 0; i < RF_LINE_WORDS; i++) begin
        r_word[i] <= '0;
      end
    end else if (i_we) begin
      case (i_idx)
        WORD0: r_word[0] <= i_wdata;
        WORD1: r_word[1] <= i_wdata;
        WORD2: r_word[2] <= i_wdata;
        WORD3: r_word[3] <= i_wdata;
      endcase
    end
  end

  for (genvar g = 0; g < RF_LINE_WORDS; g++) begin : g_line
    assign o_line[g*WORD_W +: WORD_W] = r_word[g];
  end

endmodule

// File: rtl/ic_refill_ctrl.sv
// Icache refill engine: fetches one 4-word line from the memory bus on a miss and returns it.
// Optional critical-word-first ordering under `IC_REFILL_CWF_EN.
module ic_refill_ctrl
  import ic_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int WORD_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_irq,
  input  logic [ADDR_W-1:0]     i_l2_addr,
  input  logic [1:0]            i_req_word,
  input  logic                  i_ic_rw_en,
  input  logic                  i_ext_busy,
  output logic                  o_l2_busy,
  output logic                  o_l2_rdy,
  output logic                  o_complete,
  output logic [4*WORD_W-1:0]   o_data_wd_l2,
  output logic                  o_mem_req,
  output logic [ADDR_W+1:0]     o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [WORD_W-1:0]     i_mem_rdata
);

  rf_state_t         r_state;
  rf_state_t         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_k;
  logic              w_start;
  logic              w_we;
  logic              w_last;
  logic [1:0]        w_start_k;
  logic              w_unused_ok;

`ifdef IC_REFILL_CWF_EN
  // Completion is counted in beats because k wraps and may start anywhere.
  logic [1:0] r_beats;

  assign w_start_k   = i_req_word;
  assign w_last      = (r_beats == WORD3);
  assign w_unused_ok = i_ic_rw_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beats <= WORD0;
    end else if (w_start) begin
      r_beats <= WORD0;
    end else if (w_we) begin
      r_beats <= next_word(r_beats);
    end
  end
`else
  assign w_start_k   = WORD0;
  assign w_last      = (r_k == WORD3);
  assign w_unused_ok = ^{i_ic_rw_en, i_req_word};
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RF_IDLE;
      r_addr  <= '0;
      r_k     <= WORD0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr <= i_l2_addr;
        r_k    <= w_start_k;
      end else if (w_we && !w_last) begin
        r_k <= next_word(r_k);
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_start    = DISABLE;
    w_we       = DISABLE;
    o_l2_busy  = ENABLE;
    o_l2_rdy   = DISABLE;
    o_complete = DISABLE;
    o_mem_req  = DISABLE;
    case (r_state)
      RF_IDLE: begin
        // Bus ownership is only arbitrated here; a later ext_busy is ignored.
        o_l2_busy = i_ext_busy;
        if (i_irq && !i_ext_busy) begin
          w_start = ENABLE;
          w_next  = RF_REQ;
        end
      end
      RF_REQ: begin
        o_mem_req = ENABLE;
        if (i_mem_gnt) begin
          w_next = RF_WAIT;
        end
      end
      RF_WAIT: begin
        if (i_mem_rvalid) begin
          w_we   = ENABLE;
          w_next = w_last ? RF_FILL : RF_REQ;
        end
      end
      RF_FILL: begin
        o_l2_rdy = ENABLE;
        w_next   = RF_DONE;
      end
      RF_DONE: begin
        o_complete = ENABLE;
        w_next     = RF_IDLE;
      end
      default: w_next = RF_IDLE;
    endcase
  end

  assign o_mem_addr = o_mem_req ? {r_addr, r_k} : '0;

  ic_refill_ctrl_line_buf #(
    .WORD_W (WORD_W)
  ) u_line_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start),
    .i_we    (w_we),
    .i_idx   (r_k),
    .i_wdata (i_mem_rdata),
    .o_line  (o_data_wd_l2)
  );

endmodule
